board_mem: RTL and testbench

//  Board occupancy store and responder for the game-logic FSM's board read/write interface.

---
 rtl/tetris_pkg.sv | 12 +
 rtl/board_clear_fsm.sv | 58 +++++
 rtl/board_mem.sv | 65 ++++++
 tb/tb_board_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, line-clear FSM encoding and the bounds helper shared with the game logic.
package tetris_pkg;
   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;
   localparam int X_W = 4;
   localparam int Y_W = 5;
   localparam int LINES_W = 5;
   typedef enum logic [1:0] {C_IDLE, C_SCAN, C_SHIFT, C_DONE} clear_state_e;
   function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x < X_W'(BOARD_COLS)) && (y < Y_W'(BOARD_ROWS));
   endfunction
endpackage

// File: rtl/board_clear_fsm.sv
// board_clear_fsm: bottom-up scan for full rows; each hit is shifted out and the same row re-checked.
module board_clear_fsm
   import tetris_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [BOARD_ROWS-1:0] row_full_i,
   output logic                  idle_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  shift_en_o,
   output logic [Y_W-1:0]        shift_row_o,
   output logic [LINES_W-1:0]    lines_o
);
   clear_state_e         state_q, state_d;
   logic [Y_W-1:0]       r_q, r_d;
   logic [LINES_W-1:0]   lines_q, lines_d;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= C_IDLE;
         r_q     <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         lines_q <= lines_d;
      end
   end
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      lines_d = lines_q;
      case (state_q)
         C_IDLE: if (start_i) begin
            state_d = C_SCAN;
            r_d     = Y_W'(BOARD_ROWS - 1);
            lines_d = '0;
         end
         C_SCAN: begin
            if (row_full_i[r_q]) state_d = C_SHIFT;
            else if (r_q == '0) state_d = C_DONE;
            else r_d = r_q - 1'b1;
         end
         C_SHIFT: begin
            state_d = C_SCAN;
            lines_d = lines_q + 1'b1;
         end
         default: state_d = C_IDLE;
      endcase
   end
   assign idle_o      = state_q == C_IDLE;
   assign busy_o      = (state_q == C_SCAN) || (state_q == C_SHIFT);
   assign done_o      = state_q == C_DONE;
   assign shift_en_o  = state_q == C_SHIFT;
   assign shift_row_o = r_q;
   assign lines_o     = lines_q;
endmodule

// File: rtl/board_mem.sv
// board_mem: flop-based 10x20 occupancy grid with collision/display read ports, lock writes and line clear.
module board_mem
   import tetris_pkg::*;
(
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic [X_W-1:0]     board_rx,
   input  logic [Y_W-1:0]     board_ry,
   output logic               board_rdata,
   input  logic               board_we,
   input  logic [X_W-1:0]     board_wx,
   input  logic [Y_W-1:0]     board_wy,
   input  logic               board_wdata,
   input  logic               clear_start,
   output logic               clear_busy,
   output logic               clear_done,
   output logic [LINES_W-1:0] lines_cleared,
   input  logic [X_W-1:0]     disp_rx,
   input  logic [Y_W-1:0]     disp_ry,
   output logic               disp_rdata
);
   logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] grid_q, grid_d;
   logic [BOARD_ROWS-1:0]                 row_full;
   logic                                  idle, shift_en, we_ok;
   logic [Y_W-1:0]                        shift_row;
   logic                                  board_rdata_q, disp_rdata_q;
   for (genvar g = 0; g < BOARD_ROWS; g++) begin : g_full
      assign row_full[g] = &grid_q[g];
   end
   board_clear_fsm u_fsm (
      .clk_i       (CLOCK_50),
      .rst_ni      (resetn),
      .start_i     (clear_start),
      .row_full_i  (row_full),
      .idle_o      (idle),
      .busy_o      (clear_busy),
      .done_o      (clear_done),
      .shift_en_o  (shift_en),
      .shift_row_o (shift_row),
      .lines_o     (lines_cleared)
   );
   assign we_ok = board_we && idle && in_bounds(board_wx, board_wy);
   // Shift pulls every row at or above shift_row down by one; the top row refills empty.
   always_comb begin
      grid_d = grid_q;
      if (shift_en) begin
         grid_d[0] = '0;
         for (int k = 1; k < BOARD_ROWS; k++)
            if (Y_W'(k) <= shift_row) grid_d[k] = grid_q[k-1];
      end else if (we_ok) grid_d[board_wy][board_wx] = board_wdata;
   end
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         grid_q        <= '0;
         board_rdata_q <= 1'b0;
         disp_rdata_q  <= 1'b0;
      end else begin
         grid_q        <= grid_d;
         board_rdata_q <= in_bounds(board_rx, board_ry) ? grid_q[board_ry][board_rx] : 1'b1;
         disp_rdata_q  <= in_bounds(disp_rx, disp_ry) ? grid_q[disp_ry][disp_rx] : 1'b1;
      end
   end
   assign board_rdata = board_rdata_q;
   assign disp_rdata  = disp_rdata_q;
endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: scoreboard bench for board_mem reads, writes, line clears and async reset.
module tb_board_mem;
   import tetris_pkg::*;
   logic               CLOCK_50 = 1'b0;
   logic               resetn;
   logic [X_W-1:0]     board_rx, board_wx, disp_rx;
   logic [Y_W-1:0]     board_ry, board_wy, disp_ry;
   logic               board_rdata, board_we, board_wdata, clear_start;
   logic               clear_busy, clear_done, disp_rdata;
   logic [LINES_W-1:0] lines_cleared;
   bit                 mgrid [BOARD_ROWS][BOARD_COLS];
   logic               bq[$], dq[$];
   int                 vectors = 0, miscompares = 0;
   board_mem dut (
      .CLOCK_50      (CLOCK_50),
      .resetn        (resetn),
      .board_rx      (board_rx),
      .board_ry      (board_ry),
      .board_rdata   (board_rdata),
      .board_we      (board_we),
      .board_wx      (board_wx),
      .board_wy      (board_wy),
      .board_wdata   (board_wdata),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .lines_cleared (lines_cleared),
      .disp_rx       (disp_rx),
      .disp_ry       (disp_ry),
      .disp_rdata    (disp_rdata)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask
   function automatic logic model_cell(input int x, input int y);
      return (x >= BOARD_COLS || y >= BOARD_ROWS) ? 1'b1 : mgrid[y][x];
   endfunction
   // Reference clear: keep non-full rows in order, packed to the bottom.
   function automatic int model_clear();
      bit ng [BOARD_ROWS][BOARD_COLS];
      bit full;
      int dst, n;
      ng = '{default: '{default: 1'b0}};
      dst = BOARD_ROWS - 1;
      n = 0;
      for (int s = BOARD_ROWS - 1; s >= 0; s--) begin
         full = 1'b1;
         for (int x = 0; x < BOARD_COLS; x++) full &= mgrid[s][x];
         if (full) n++;
         else begin
            ng[dst] = mgrid[s];
            dst--;
         end
      end
      mgrid = ng;
      return n;
   endfunction
   task automatic rd(input int x, input int y);
      board_rx = X_W'(x);
      board_ry = Y_W'(y);
      disp_rx  = X_W'(x);
      disp_ry  = Y_W'(y);
      bq.push_back(model_cell(x, y));
      dq.push_back(model_cell(x, y));
      tick;
      check($sformatf("board_rd(%0d,%0d)", x, y), board_rdata, bq.pop_front());
      check($sformatf("disp_rd(%0d,%0d)", x, y), disp_rdata, dq.pop_front());
   endtask
   task automatic rd_all;
      for (int y = 0; y < BOARD_ROWS; y++)
         for (int x = 0; x < BOARD_COLS; x++) rd(x, y);
   endtask
   task automatic wr(input int x, input int y, input bit d);
      board_we    = 1'b1;
      board_wx    = X_W'(x);
      board_wy    = Y_W'(y);
      board_wdata = d;
      tick;
      board_we = 1'b0;
      if (x < BOARD_COLS && y < BOARD_ROWS) mgrid[y][x] = d;
   endtask
   task automatic do_clear(input int exp_busy, input bit poke);
      int n, lines;
      clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      board_we    = 1'b0;
      lines = model_clear();
      n = 0;
      while (clear_busy === 1'b1 && n < 100) begin
         if (poke && n == 1) begin
            board_we    = 1'b1;
            board_wx    = '0;
            board_wy    = '0;
            board_wdata = 1'b1;
         end else board_we = 1'b0;
         n++;
         tick;
      end
      board_we = 1'b0;
      check("busy_cycles", n, exp_busy);
      check("done_pulse", clear_done, 1);
      check("lines_cleared", lines_cleared, lines);
      tick;
      check("done_low", clear_done, 0);
      check("lines_hold", lines_cleared, lines);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      mgrid = '{default: '{default: 1'b0}};
      resetn = 1'b0;
      {board_rx, board_ry, disp_rx, disp_ry, board_wx, board_wy} = '0;
      {board_we, board_wdata, clear_start} = '0;
      repeat (3) tick;
      check("rst_board_rdata", board_rdata, 0);
      check("rst_disp_rdata", disp_rdata, 0);
      check("rst_busy", clear_busy, 0);
      check("rst_done", clear_done, 0);
      check("rst_lines", lines_cleared, 0);
      resetn = 1'b1;
      tick;
      // reads, walls, empty-board clear latency
      rd(3, 7);
      rd(10, 0);
      rd(0, 20);
      do_clear(20, 1'b0);
      // writes, out-of-range drop, read-during-write
      wr(0, 19, 1'b1);
      rd(0, 19);
      wr(12, 5, 1'b1);
      rd(12, 5);
      board_rx = 3; board_ry = 3; disp_rx = 3; disp_ry = 3;
      bq.push_back(1'b0);
      dq.push_back(1'b0);
      wr(3, 3, 1'b1);
      check("rdw_board_old", board_rdata, bq.pop_front());
      check("rdw_disp_old", disp_rdata, dq.pop_front());
      rd(3, 3);
      wr(3, 3, 1'b0);
      rd_all;
      // single full row with a block above it
      for (int x = 0; x < BOARD_COLS; x++) wr(x, 19, 1'b1);
      wr(7, 18, 1'b1);
      do_clear(22, 1'b0);
      rd_all;
      // rows 19 and 17 full around a lone block at (4,18)
      for (int x = 0; x < BOARD_COLS; x++) wr(x, 19, 1'b1);
      for (int x = 0; x < BOARD_COLS; x++) wr(x, 17, 1'b1);
      wr(7, 19, 1'b1);
      wr(4, 18, 1'b1);
      do_clear(24, 1'b0);
      rd_all;
      // write lands with clear_start and completes row 19; write during busy dropped
      for (int x = 0; x < BOARD_COLS; x++) if (x != 5) wr(x, 19, 1'b1);
      board_we = 1'b1; board_wx = 5; board_wy = 19; board_wdata = 1'b1;
      mgrid[19][5] = 1'b1;
      do_clear(22, 1'b1);
      rd_all;
      // async reset in the middle of a shift
      for (int x = 0; x < BOARD_COLS; x++) wr(x, 19, 1'b1);
      wr(2, 10, 1'b1);
      clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      tick;
      check("pre_rst_busy", clear_busy, 1);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_busy", clear_busy, 0);
      check("mid_rst_done", clear_done, 0);
      check("mid_rst_lines", lines_cleared, 0);
      check("mid_rst_rdata", board_rdata, 0);
      check("mid_rst_disp", disp_rdata, 0);
      mgrid = '{default: '{default: 1'b0}};
      @(negedge CLOCK_50);
      resetn = 1'b1;
      tick;
      rd_all;
      do_clear(20, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
